// File: rtl/sram22_req_ctrl_if.sv
// Request/response channel bundle between a requester and the sram22_req_ctrl front-end.
// The master modport is the requester side; the slave modport is the controller side.
interface sram22_req_ctrl_if #(
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 9,
    parameter int WMASK_WIDTH = DATA_WIDTH / 8
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [WMASK_WIDTH-1:0] req_wmask;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram22_req_ctrl.sv
// Front-end for a byte-masked SRAM22 macro: drives the macro pins from accepted requests and
// buffers 1-cycle-latency read data in a credit-protected response FIFO.
module sram22_req_ctrl #(
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 9,
    parameter int WMASK_WIDTH = DATA_WIDTH / 8,
    parameter int RSP_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rstb,
    sram22_req_ctrl_if.slave       bus,
    output logic                   sram_rstb,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout,
    output logic                   idle
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    // One extra bit so count + in-flight read never wraps in the credit compare.
    localparam int CNT_W = $clog2(RSP_DEPTH + 1) + 1;

    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];

    logic             push;
    logic             pop;
    logic             accept;
    logic             req_ready;
    logic [CNT_W-1:0] occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        push          = rd_inflight_q;
        pop           = (count_q != '0) && bus.rsp_ready;
        occupancy     = count_q + CNT_W'(rd_inflight_q) - CNT_W'(pop);
        req_ready     = rstb && (occupancy < CNT_W'(RSP_DEPTH));
        accept        = bus.req_valid && req_ready;
        rd_inflight_d = accept && !bus.req_we;
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    // Response storage is deliberately not reset; rsp_rdata is only meaningful with rsp_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sram_dout;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (count_q != '0);
    assign bus.rsp_rdata = mem_q[rd_ptr_q];

    assign sram_rstb  = rstb;
    assign sram_ce    = accept;
    assign sram_we    = bus.req_we;
    assign sram_addr  = bus.req_addr;
    assign sram_wmask = bus.req_wmask;
    assign sram_din   = bus.req_wdata;

    assign idle = !rd_inflight_q && (count_q == '0);
endmodule

// File: tb/tb_sram22_req_ctrl.sv
// Directed self-checking bench for sram22_req_ctrl with a behavioural SRAM22 macro model
// and a scoreboard queue of expected read data.
module tb_sram22_req_ctrl;
    localparam int DW = 128;
    localparam int AW = 9;
    localparam int MW = 16;
    localparam int DEPTH = 2;

    logic          clk;
    logic          rstb;
    logic          sram_rstb;
    logic          sram_ce;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
    logic          idle;

    sram22_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

    sram22_req_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .bus        (bus),
        .sram_rstb  (sram_rstb),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout),
        .idle       (idle)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int rsp_count = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sram_mem [512];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pattern(input int a);
        logic [31:0] w;
        w = (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
        return {w, ~w, w + 32'd1, 32'(a)};
    endfunction

    // Behavioural macro: masked write commits at the sampling edge, read data one cycle later.
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < MW; b++) begin
                    if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: every handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstb) begin
            check("fifo_bound", DW'(dut.count_q <= DEPTH), DW'(1));
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("rsp_pending", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) begin
                    check("rsp_data", bus.rsp_rdata, exp_q.pop_front());
                end
                rsp_count++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [MW-1:0] mask,
                                 input logic [DW-1:0] data, input logic [DW-1:0] exp, input int max_wait);
        logic ok;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wmask = mask;
        bus.req_wdata = data;
        for (int i = 0; i <= max_wait; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("accept", DW'(ok), DW'(1));
        if (ok) begin
            check("sram_ce", DW'(sram_ce), DW'(1));
            check("sram_we", DW'(sram_we), DW'(we));
            check("sram_addr", DW'(sram_addr), DW'(addr));
            check("sram_wmask", DW'(sram_wmask), DW'(mask));
            check("sram_din", sram_din, data);
            if (!we) exp_q.push_back(exp);
            step();
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int cycles);
        for (int i = 0; i < cycles && exp_q.size() != 0; i++) step();
        check(tag, DW'(exp_q.size()), DW'(0));
    endtask

    localparam logic [DW-1:0] WR_DATA   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DW-1:0] ONES      = {DW{1'b1}};
    localparam logic [DW-1:0] MASK_EXP  = {{(DW-8){1'b1}}, 8'h00};

    initial begin
        int base;
        for (int i = 0; i < 512; i++) sram_mem[i] = pattern(i);
        sram_dout     = '0;
        rstb          = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wmask = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) step();
        @(negedge clk);
        check("rst_req_ready", DW'(bus.req_ready), DW'(0));
        check("rst_sram_ce", DW'(sram_ce), DW'(0));
        check("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        check("rst_idle", DW'(idle), DW'(1));
        check("rst_sram_rstb", DW'(sram_rstb), DW'(0));
        bus.req_valid = 1'b0;
        step();
        rstb = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", DW'(bus.req_ready), DW'(1));
        check("post_rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        check("post_rst_idle", DW'(idle), DW'(1));
        check("post_rst_sram_ce", DW'(sram_ce), DW'(0));
        check("post_rst_sram_rstb", DW'(sram_rstb), DW'(1));
        step();

        $display("[TB] write then back-to-back read of 0x1A5");
        bus.rsp_ready = 1'b1;
        applyStimulus(1'b1, 9'h1A5, 16'hFFFF, WR_DATA, '0, 0);
        applyStimulus(1'b0, 9'h1A5, 16'h0000, '0, WR_DATA, 0);
        check("rd_lat_early", DW'(bus.rsp_valid), DW'(0));
        check("rd_busy", DW'(idle), DW'(0));
        step();
        check("rd_lat_valid", DW'(bus.rsp_valid), DW'(1));
        check("rd_lat_data", bus.rsp_rdata, WR_DATA);
        checkOutput("rd_drain", 4);

        $display("[TB] byte mask and empty mask");
        applyStimulus(1'b1, 9'h000, 16'hFFFF, ONES, '0, 0);
        applyStimulus(1'b1, 9'h000, 16'h0001, '0, '0, 0);
        applyStimulus(1'b0, 9'h000, 16'h0000, '0, MASK_EXP, 0);
        applyStimulus(1'b1, 9'h005, 16'h0000, ONES, '0, 0);
        applyStimulus(1'b0, 9'h005, 16'h0000, '0, pattern(5), 0);
        checkOutput("mask_drain", 6);

        $display("[TB] response backpressure");
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b0, 9'd1, 16'h0, '0, pattern(1), 0);
        applyStimulus(1'b0, 9'd2, 16'h0, '0, pattern(2), 0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 9'd3;
        @(negedge clk);
        check("bp_ready_low", DW'(bus.req_ready), DW'(0));
        check("bp_no_ce", DW'(sram_ce), DW'(0));
        step();
        step();
        @(negedge clk);
        check("bp_ready_held", DW'(bus.req_ready), DW'(0));
        check("bp_rsp_valid", DW'(bus.rsp_valid), DW'(1));
        check("bp_full", DW'(dut.count_q), DW'(2));
        step();
        bus.rsp_ready = 1'b1;
        applyStimulus(1'b0, 9'd3, 16'h0, '0, pattern(3), 4);
        checkOutput("bp_drain", 8);

        $display("[TB] 64 back-to-back reads");
        base = rsp_count;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, AW'(100 + i), 16'h0, '0, pattern(100 + i), 0);
        end
        check("stream_seen_62", DW'(rsp_count - base), DW'(62));
        step();
        check("stream_last_valid", DW'(bus.rsp_valid), DW'(1));
        check("stream_seen_63", DW'(rsp_count - base), DW'(63));
        step();
        check("stream_seen_64", DW'(rsp_count - base), DW'(64));
        check("stream_empty", DW'(exp_q.size()), DW'(0));

        $display("[TB] reset with a read in flight");
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b0, 9'd7, 16'h0, '0, pattern(7), 0);
        rstb = 1'b0;
        exp_q.delete();
        base = rsp_count;
        #1;
        check("midrst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        check("midrst_idle", DW'(idle), DW'(1));
        step();
        rstb = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (5) step();
        check("midrst_no_rsp", DW'(rsp_count - base), DW'(0));
        check("midrst_idle_after", DW'(idle), DW'(1));
        check("midrst_valid_after", DW'(bus.rsp_valid), DW'(0));

        check("final_empty", DW'(exp_q.size()), DW'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation timed out");
    end
endmodule
